// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-ported data SRAM.
// Port 0 (core) has priority. Port 1 (loader/debug) takes over after
// MAX_WAIT consecutive denied cycles. Grants are combinational. Read data
// comes back one cycle after the grant and is routed to the port that won.
//
// Ports:
//   CLK, RSTn                 clock, asynchronous active-low reset
//   Px_REQ/WE/BE/ADDR/WDATA   request command from port x (x = 0, 1)
//   Px_GNT                    request accepted this cycle (combinational)
//   Px_RVALID, Px_RDATA       read return; RDATA holds when RVALID is low
//   MEM_CSN/WEN/BE/ADDR/DOUT  SRAM command (active-low select and write)
//   MEM_DI                    SRAM read data, one cycle after the select
//   WAIT_CNT                  port-1 starvation counter (debug)
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned AWIDTH   = 12
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              P0_REQ,
    input  logic              P0_WE,
    input  logic [3:0]        P0_BE,
    input  logic [AWIDTH-1:0] P0_ADDR,
    input  logic [31:0]       P0_WDATA,
    output logic              P0_GNT,
    output logic              P0_RVALID,
    output logic [31:0]       P0_RDATA,
    input  logic              P1_REQ,
    input  logic              P1_WE,
    input  logic [3:0]        P1_BE,
    input  logic [AWIDTH-1:0] P1_ADDR,
    input  logic [31:0]       P1_WDATA,
    output logic              P1_GNT,
    output logic              P1_RVALID,
    output logic [31:0]       P1_RDATA,
    output logic              MEM_CSN,
    output logic              MEM_WEN,
    output logic [3:0]        MEM_BE,
    output logic [AWIDTH-1:0] MEM_ADDR,
    output logic [31:0]       MEM_DOUT,
    input  logic [31:0]       MEM_DI,
    output logic [3:0]        WAIT_CNT
);

    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(15);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             rd_vld_q, rd_vld_d;
    logic             rd_own_q, rd_own_d;   // 0: port 0, 1: port 1
    logic [31:0]      rdata0_q, rdata1_q;
    logic             p1_wins;

    // Arbitration and SRAM command mux; reset forces the bus idle asynchronously
    always_comb begin
        p1_wins  = P1_REQ & (~P0_REQ | (32'(wait_cnt_q) >= MAX_WAIT));
        P1_GNT   = RSTn & p1_wins;
        P0_GNT   = RSTn & P0_REQ & ~p1_wins;
        MEM_CSN  = 1'b1;
        MEM_WEN  = 1'b1;
        MEM_BE   = '0;
        MEM_ADDR = '0;
        MEM_DOUT = '0;
        if (P1_GNT) begin
            MEM_CSN  = 1'b0;
            MEM_WEN  = ~P1_WE;
            MEM_BE   = P1_BE;
            MEM_ADDR = P1_ADDR;
            MEM_DOUT = P1_WDATA;
        end else if (P0_GNT) begin
            MEM_CSN  = 1'b0;
            MEM_WEN  = ~P0_WE;
            MEM_BE   = P0_BE;
            MEM_ADDR = P0_ADDR;
            MEM_DOUT = P0_WDATA;
        end
    end

    // Next-state: starvation counter (clear beats saturate) and read owner
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        rd_vld_d   = 1'b0;
        rd_own_d   = rd_own_q;
        if (P1_GNT) begin
            wait_cnt_d = '0;
        end else if (P1_REQ && (wait_cnt_q != CNT_SAT)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
        if (P1_GNT && !P1_WE) begin
            rd_vld_d = 1'b1;
            rd_own_d = 1'b1;
        end else if (P0_GNT && !P0_WE) begin
            rd_vld_d = 1'b1;
            rd_own_d = 1'b0;
        end
    end

    // State registers; the read-data holds capture MEM_DI while their port is valid
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wait_cnt_q <= '0;
            rd_vld_q   <= 1'b0;
            rd_own_q   <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_vld_q   <= rd_vld_d;
            rd_own_q   <= rd_own_d;
            if (P0_RVALID) rdata0_q <= MEM_DI;
            if (P1_RVALID) rdata1_q <= MEM_DI;
        end
    end

    // Read return: valid is a flop, data passes MEM_DI through while valid
    always_comb begin
        P0_RVALID = rd_vld_q & ~rd_own_q;
        P1_RVALID = rd_vld_q &  rd_own_q;
        P0_RDATA  = P0_RVALID ? MEM_DI : rdata0_q;
        P1_RDATA  = P1_RVALID ? MEM_DI : rdata1_q;
        WAIT_CNT  = wait_cnt_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural one-cycle SRAM.
module tb_dmem_arbiter;

    logic        CLK;
    logic        RSTn;
    logic        P0_REQ, P0_WE, P1_REQ, P1_WE;
    logic [3:0]  P0_BE, P1_BE;
    logic [11:0] P0_ADDR, P1_ADDR;
    logic [31:0] P0_WDATA, P1_WDATA;
    logic        P0_GNT, P0_RVALID, P1_GNT, P1_RVALID;
    logic [31:0] P0_RDATA, P1_RDATA;
    logic        MEM_CSN, MEM_WEN;
    logic [3:0]  MEM_BE;
    logic [11:0] MEM_ADDR;
    logic [31:0] MEM_DOUT, MEM_DI;
    logic [3:0]  WAIT_CNT;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:1023];
    logic [31:0] mem_q;

    dmem_arbiter #(.MAX_WAIT(4), .AWIDTH(12)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .P0_REQ(P0_REQ), .P0_WE(P0_WE), .P0_BE(P0_BE), .P0_ADDR(P0_ADDR),
        .P0_WDATA(P0_WDATA), .P0_GNT(P0_GNT), .P0_RVALID(P0_RVALID), .P0_RDATA(P0_RDATA),
        .P1_REQ(P1_REQ), .P1_WE(P1_WE), .P1_BE(P1_BE), .P1_ADDR(P1_ADDR),
        .P1_WDATA(P1_WDATA), .P1_GNT(P1_GNT), .P1_RVALID(P1_RVALID), .P1_RDATA(P1_RDATA),
        .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_BE(MEM_BE), .MEM_ADDR(MEM_ADDR),
        .MEM_DOUT(MEM_DOUT), .MEM_DI(MEM_DI), .WAIT_CNT(WAIT_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SRAM model: contents set up at time 0, byte-masked writes, registered reads
    always @(posedge CLK) begin
        if (!MEM_CSN) begin
            if (!MEM_WEN) begin
                for (int b = 0; b < 4; b++)
                    if (MEM_BE[b]) mem[MEM_ADDR[11:2]][b*8 +: 8] = MEM_DOUT[b*8 +: 8];
            end else begin
                mem_q <= mem[MEM_ADDR[11:2]];
            end
        end
    end
    assign MEM_DI = mem_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        P0_REQ = 0; P0_WE = 0; P0_BE = 0; P0_ADDR = 0; P0_WDATA = 0;
        P1_REQ = 0; P1_WE = 0; P1_BE = 0; P1_ADDR = 0; P1_WDATA = 0;
    endtask

    task automatic set_p0(input logic req, input logic we, input logic [3:0] be,
                          input logic [11:0] addr, input logic [31:0] wd);
        P0_REQ = req; P0_WE = we; P0_BE = be; P0_ADDR = addr; P0_WDATA = wd;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [3:0] be,
                          input logic [11:0] addr, input logic [31:0] wd);
        P1_REQ = req; P1_WE = we; P1_BE = be; P1_ADDR = addr; P1_WDATA = wd;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] exp_p1 = 10'b1000010000;   // bit i = cycle i, P1 wins on 4 and 9
        logic [3:0] exp_cnt [10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};

        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[4]  = 32'h1234_5678;
        mem[8]  = 32'h1122_3344;
        mem[12] = 32'hCAFE_0001;
        mem[16] = 32'hCAFE_0002;
        mem[20] = 32'hCAFE_0003;
        mem_q = 0;
        set_idle();
        RSTn = 0;

        // Reset state, with both ports requesting
        repeat (2) @(negedge CLK);
        P0_REQ = 1; P1_REQ = 1; #1;
        check("rst_gnt0",   32'(P0_GNT), 0);
        check("rst_gnt1",   32'(P1_GNT), 0);
        check("rst_csn",    32'(MEM_CSN), 1);
        check("rst_wen",    32'(MEM_WEN), 1);
        check("rst_be",     32'(MEM_BE), 0);
        check("rst_rv0",    32'(P0_RVALID), 0);
        check("rst_rv1",    32'(P1_RVALID), 0);
        check("rst_rdata0", P0_RDATA, 0);
        check("rst_rdata1", P1_RDATA, 0);
        check("rst_wcnt",   32'(WAIT_CNT), 0);
        set_idle();
        @(negedge CLK);
        RSTn = 1;
        next_cycle();

        // Single P0 read: same-cycle grant, data next cycle only
        set_p0(1, 0, 4'hF, 12'h010, 0);
        @(negedge CLK);
        check("rd0_gnt0", 32'(P0_GNT), 1);
        check("rd0_gnt1", 32'(P1_GNT), 0);
        check("rd0_csn",  32'(MEM_CSN), 0);
        check("rd0_wen",  32'(MEM_WEN), 1);
        check("rd0_addr", 32'(MEM_ADDR), 32'h010);
        next_cycle();
        set_idle();
        @(negedge CLK);
        check("rd0_rv0",   32'(P0_RVALID), 1);
        check("rd0_rdata", P0_RDATA, 32'h1234_5678);
        check("rd0_rv1",   32'(P1_RVALID), 0);
        check("idle_csn",  32'(MEM_CSN), 1);
        next_cycle();
        @(negedge CLK);
        check("rd0_rv0_off", 32'(P0_RVALID), 0);
        check("rd0_hold",    P0_RDATA, 32'h1234_5678);

        // Continuous contention: P0 x4 then P1, repeating
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            set_p0(1, 0, 4'hF, 12'h100, 0);
            set_p1(1, 0, 4'hF, 12'h200, 0);
            @(negedge CLK);
            check($sformatf("arb_gnt1_%0d", i), 32'(P1_GNT), 32'(exp_p1[i]));
            check($sformatf("arb_gnt0_%0d", i), 32'(P0_GNT), 32'(!exp_p1[i]));
            check($sformatf("arb_wcnt_%0d", i), 32'(WAIT_CNT), 32'(exp_cnt[i]));
            next_cycle();
        end

        // P1 alone at WAIT_CNT=3: immediate grant, counter clears
        for (int i = 0; i < 3; i++) next_cycle();
        P0_REQ = 0;
        @(negedge CLK);
        check("alone_wcnt3", 32'(WAIT_CNT), 3);
        check("alone_gnt1",  32'(P1_GNT), 1);
        check("alone_gnt0",  32'(P0_GNT), 0);
        next_cycle();
        set_idle();
        @(negedge CLK);
        check("alone_wcnt0", 32'(WAIT_CNT), 0);

        // P1 partial write, then P0 reads back the merged word
        next_cycle();
        set_p1(1, 1, 4'b0011, 12'h020, 32'hDEAD_BEEF);
        @(negedge CLK);
        check("wr_gnt1", 32'(P1_GNT), 1);
        check("wr_wen",  32'(MEM_WEN), 0);
        check("wr_be",   32'(MEM_BE), 32'h3);
        check("wr_dout", MEM_DOUT, 32'hDEAD_BEEF);
        check("wr_addr", 32'(MEM_ADDR), 32'h020);
        next_cycle();
        set_idle();
        set_p0(1, 0, 4'hF, 12'h020, 0);
        @(negedge CLK);
        check("wr_no_rv1", 32'(P1_RVALID), 0);
        check("rb_gnt0",   32'(P0_GNT), 1);
        next_cycle();
        set_idle();
        @(negedge CLK);
        check("rb_rv0",    32'(P0_RVALID), 1);
        check("rb_rdata",  P0_RDATA, 32'h1122_BEEF);
        check("idle_addr", 32'(MEM_ADDR), 0);
        check("idle_dout", MEM_DOUT, 0);
        check("idle_be",   32'(MEM_BE), 0);

        // Back-to-back reads P0, P1, P0 return in grant order
        next_cycle();
        set_p0(1, 0, 4'hF, 12'h030, 0);
        @(negedge CLK);
        check("b2b_gnt0_a", 32'(P0_GNT), 1);
        next_cycle();
        set_idle();
        set_p1(1, 0, 4'hF, 12'h040, 0);
        @(negedge CLK);
        check("b2b_gnt1",   32'(P1_GNT), 1);
        check("b2b_rv0_a",  32'(P0_RVALID), 1);
        check("b2b_d0_a",   P0_RDATA, 32'hCAFE_0001);
        next_cycle();
        set_idle();
        set_p0(1, 0, 4'hF, 12'h050, 0);
        @(negedge CLK);
        check("b2b_rv1",    32'(P1_RVALID), 1);
        check("b2b_d1",     P1_RDATA, 32'hCAFE_0002);
        check("b2b_rv0_lo", 32'(P0_RVALID), 0);
        check("b2b_hold0",  P0_RDATA, 32'hCAFE_0001);
        next_cycle();
        set_idle();
        @(negedge CLK);
        check("b2b_rv0_b",  32'(P0_RVALID), 1);
        check("b2b_d0_b",   P0_RDATA, 32'hCAFE_0003);
        check("b2b_rv1_lo", 32'(P1_RVALID), 0);
        check("b2b_hold1",  P1_RDATA, 32'hCAFE_0002);

        // Reset right after a granted P1 read aborts its return
        next_cycle();
        set_p0(1, 0, 4'hF, 12'h100, 0);
        set_p1(1, 0, 4'hF, 12'h200, 0);
        next_cycle();
        next_cycle();
        set_idle();
        set_p1(1, 0, 4'hF, 12'h040, 0);
        @(negedge CLK);
        check("ra_gnt1", 32'(P1_GNT), 1);
        check("ra_wcnt", 32'(WAIT_CNT), 2);
        #1 RSTn = 0;
        #1;
        check("ra_gnt1_rst", 32'(P1_GNT), 0);
        check("ra_csn_rst",  32'(MEM_CSN), 1);
        check("ra_wen_rst",  32'(MEM_WEN), 1);
        check("ra_be_rst",   32'(MEM_BE), 0);
        check("ra_d0_rst",   P0_RDATA, 0);
        check("ra_d1_rst",   P1_RDATA, 0);
        check("ra_wcnt_rst", 32'(WAIT_CNT), 0);
        @(negedge CLK);
        check("ra_rv1", 32'(P1_RVALID), 0);
        check("ra_rv0", 32'(P0_RVALID), 0);
        set_idle();
        #1 RSTn = 1;
        next_cycle();
        set_p0(1, 0, 4'hF, 12'h100, 0);
        set_p1(1, 0, 4'hF, 12'h200, 0);
        @(negedge CLK);
        check("post_gnt0", 32'(P0_GNT), 1);
        check("post_gnt1", 32'(P1_GNT), 0);
        check("post_wcnt", 32'(WAIT_CNT), 0);
        next_cycle();
        set_idle();
        @(negedge CLK);
        check("post_wcnt1", 32'(WAIT_CNT), 1);
        check("post_rv1",   32'(P1_RVALID), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
